// File: rtl/alarm_timebase_if.sv
// Control/status bundle between the alarm timebase and its controller (snooze line only with ALARM_SNOOZE_EN).
interface alarm_timebase_if;
  logic       set_en;
  logic       set_sel;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [2:0] set_day;
  logic       alarm_enable;
  logic       stop;
`ifdef ALARM_SNOOZE_EN
  logic       snooze;
`endif
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [2:0] day;
  logic       sec_pulse;
  logic       weekday;
  logic       alarm_req;
  logic       set_err;

  modport master (
    output set_en, set_sel, set_hour, set_min, set_day, alarm_enable, stop,
`ifdef ALARM_SNOOZE_EN
    output snooze,
`endif
    input  sec, min, hour, day, sec_pulse, weekday, alarm_req, set_err
  );

  modport slave (
    input  set_en, set_sel, set_hour, set_min, set_day, alarm_enable, stop,
`ifdef ALARM_SNOOZE_EN
    input  snooze,
`endif
    output sec, min, hour, day, sec_pulse, weekday, alarm_req, set_err
  );
endinterface

// File: rtl/alarm_timebase.sv
// Time-of-day/day-of-week timebase with one programmable alarm; 1 Hz tick derived from clk.
// ALARM_SNOOZE_EN adds the snooze input and a SNOOZE state that re-rings after SNOOZE_MIN minutes.
module alarm_timebase #(
  parameter int TICKS_PER_SEC  = 100,
  parameter int ALARM_HOLD_SEC = 60
`ifdef ALARM_SNOOZE_EN
  , parameter int SNOOZE_MIN   = 5
`endif
) (
  input  logic             clk,
  input  logic             reset,
  alarm_timebase_if.slave  bus
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int RW = $clog2(ALARM_HOLD_SEC + 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [RW-1:0] RING_MAX = RW'(ALARM_HOLD_SEC - 1);
`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_MIN + 1);
  localparam logic [SW-1:0] SNZ_MAX = SW'(SNOOZE_MIN - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1
`ifdef ALARM_SNOOZE_EN
    , ST_SNOOZE = 2'd2
`endif
  } state_e;

  logic [PW-1:0] pre_q, pre_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic [2:0]    day_q, day_d;
  logic [4:0]    alm_hour_q, alm_hour_d;
  logic [5:0]    alm_min_q, alm_min_d;
  logic          pulse_q, pulse_d;
  logic          err_q, err_d;
  state_e        state_q;
  logic          alarm_req_q;
  logic [RW-1:0] ring_q;
`ifdef ALARM_SNOOZE_EN
  logic [SW-1:0] snz_q;
`endif

  logic time_ok, alarm_ok, time_ld, alarm_ld, wrap, trigger;

  always_comb begin
    time_ok  = (bus.set_hour <= 5'd23) && (bus.set_min <= 6'd59) && (bus.set_day <= 3'd6);
    alarm_ok = (bus.set_hour <= 5'd23) && (bus.set_min <= 6'd59);
    time_ld  = bus.set_en && !bus.set_sel && time_ok;
    alarm_ld = bus.set_en && bus.set_sel && alarm_ok;
    err_d    = bus.set_en && !(bus.set_sel ? alarm_ok : time_ok);
    wrap     = (pre_q == PRE_MAX);

    pre_d      = wrap ? '0 : pre_q + 1'b1;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    day_d      = day_q;
    pulse_d    = 1'b0;
    alm_hour_d = alm_hour_q;
    alm_min_d  = alm_min_q;

    // A time load restarts the second, so a coincident tick is dropped.
    if (time_ld) begin
      pre_d  = '0;
      sec_d  = '0;
      min_d  = bus.set_min;
      hour_d = bus.set_hour;
      day_d  = bus.set_day;
    end else if (wrap) begin
      pulse_d = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d = '0;
          if (hour_q == 5'd23) begin
            hour_d = '0;
            day_d  = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    if (alarm_ld) begin
      alm_hour_d = bus.set_hour;
      alm_min_d  = bus.set_min;
    end

    trigger = pulse_q && (sec_q == 6'd0) && (min_q == alm_min_q) &&
              (hour_q == alm_hour_q) && bus.alarm_enable;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q      <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      day_q      <= '0;
      alm_hour_q <= '0;
      alm_min_q  <= '0;
      pulse_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      day_q      <= day_d;
      alm_hour_q <= alm_hour_d;
      alm_min_q  <= alm_min_d;
      pulse_q    <= pulse_d;
      err_q      <= err_d;
    end
  end

  // Stop has top priority in every state; pulse_q marks the cycle the counters show the new second.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      alarm_req_q <= 1'b0;
      ring_q      <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger && !bus.stop) begin
            state_q     <= ST_RINGING;
            alarm_req_q <= 1'b1;
            ring_q      <= '0;
          end
        end
        ST_RINGING: begin
          if (bus.stop || time_ld) begin
            state_q     <= ST_IDLE;
            alarm_req_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (bus.snooze) begin
            state_q     <= ST_SNOOZE;
            alarm_req_q <= 1'b0;
            snz_q       <= '0;
`endif
          end else if (pulse_q) begin
            if (ring_q == RING_MAX) begin
              state_q     <= ST_IDLE;
              alarm_req_q <= 1'b0;
            end else begin
              ring_q <= ring_q + 1'b1;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (bus.stop || time_ld) begin
            state_q     <= ST_IDLE;
            alarm_req_q <= 1'b0;
          end else if (pulse_q && (sec_q == 6'd0)) begin
            if (snz_q == SNZ_MAX) begin
              state_q     <= ST_RINGING;
              alarm_req_q <= 1'b1;
              ring_q      <= '0;
            end else begin
              snz_q <= snz_q + 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q     <= ST_IDLE;
          alarm_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sec       = sec_q;
  assign bus.min       = min_q;
  assign bus.hour      = hour_q;
  assign bus.day       = day_q;
  assign bus.sec_pulse = pulse_q;
  assign bus.weekday   = (day_q <= 3'd4);
  assign bus.alarm_req = alarm_req_q;
  assign bus.set_err   = err_q;

endmodule

// File: tb/tb_alarm_timebase.sv
// Directed bench for alarm_timebase at 4 ticks per second; snooze checks build only with ALARM_SNOOZE_EN.
module tb_alarm_timebase;
  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hi_pulses;

  alarm_timebase_if bus ();

  alarm_timebase #(.TICKS_PER_SEC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input logic [4:0] h, input logic [5:0] m, input logic [2:0] d);
    bus.set_en   = 1'b1;
    bus.set_sel  = sel;
    bus.set_hour = h;
    bus.set_min  = m;
    bus.set_day  = d;
    cyc(1);
    bus.set_en   = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    bus.set_en       = 1'b0;
    bus.set_sel      = 1'b0;
    bus.set_hour     = '0;
    bus.set_min      = '0;
    bus.set_day      = '0;
    bus.alarm_enable = 1'b0;
    bus.stop         = 1'b0;
`ifdef ALARM_SNOOZE_EN
    bus.snooze       = 1'b0;
`endif
    cyc(2);
    check("rst_sec",     32'(bus.sec), 0);
    check("rst_min",     32'(bus.min), 0);
    check("rst_hour",    32'(bus.hour), 0);
    check("rst_day",     32'(bus.day), 0);
    check("rst_weekday", 32'(bus.weekday), 1);
    check("rst_req",     32'(bus.alarm_req), 0);
    check("rst_pulse",   32'(bus.sec_pulse), 0);
    check("rst_err",     32'(bus.set_err), 0);
    reset = 1'b0;

    cyc(3);  check("pulse_early", 32'(bus.sec_pulse), 0);
    cyc(1);  check("pulse_1",     32'(bus.sec_pulse), 1);
             check("sec_1",       32'(bus.sec), 1);
    cyc(1);  check("pulse_1_off", 32'(bus.sec_pulse), 0);
    cyc(3);  check("pulse_2",     32'(bus.sec_pulse), 1);
             check("sec_2",       32'(bus.sec), 2);

    // Full rollover 23:59 Sun -> 00:00 Mon
    load(1'b0, 5'd23, 6'd59, 3'd6);
    check("ld_hour", 32'(bus.hour), 23);
    check("ld_day",  32'(bus.day), 6);
    check("ld_wkd",  32'(bus.weekday), 0);
    cyc(240);
    check("roll_sec",  32'(bus.sec), 0);
    check("roll_min",  32'(bus.min), 0);
    check("roll_hour", 32'(bus.hour), 0);
    check("roll_day",  32'(bus.day), 0);
    check("roll_wkd",  32'(bus.weekday), 1);
    load(1'b0, 5'd0, 6'd0, 3'd5);
    check("sat_wkd", 32'(bus.weekday), 0);

    // Rejected loads
    load(1'b0, 5'd24, 6'd10, 3'd0);
    check("bad_hour_err",  32'(bus.set_err), 1);
    check("bad_hour_keep", 32'(bus.day), 5);
    check("bad_hour_min",  32'(bus.min), 0);
    cyc(1);
    check("err_one_cycle", 32'(bus.set_err), 0);
    load(1'b1, 5'd7, 6'd60, 3'd0);
    check("bad_alm_err", 32'(bus.set_err), 1);

    // Load coinciding with prescaler wrap
    load(1'b0, 5'd10, 6'd20, 3'd2);
    cyc(3);
    load(1'b0, 5'd10, 6'd21, 3'd2);
    check("wrap_ld_sec",   32'(bus.sec), 0);
    check("wrap_ld_pulse", 32'(bus.sec_pulse), 0);
    check("wrap_ld_min",   32'(bus.min), 21);
    cyc(3);  check("wrap_ld_quiet", 32'(bus.sec_pulse), 0);
    cyc(1);  check("wrap_ld_next",  32'(bus.sec), 1);

    // Alarm at 07:30, stop 3 s after it rises
    load(1'b1, 5'd7, 6'd30, 3'd0);
    bus.alarm_enable = 1'b1;
    load(1'b0, 5'd7, 6'd29, 3'd1);
    cyc(239);
    check("pre_alarm_req", 32'(bus.alarm_req), 0);
    cyc(1);
    check("s0_pulse", 32'(bus.sec_pulse), 1);
    check("s0_min",   32'(bus.min), 30);
    check("s0_req",   32'(bus.alarm_req), 0);
    cyc(1);
    check("req_rise", 32'(bus.alarm_req), 1);
    cyc(11);
    check("req_at_3s", 32'(bus.alarm_req), 1);
    pulse_stop();
    check("req_stopped", 32'(bus.alarm_req), 0);
    cyc(8);
    check("req_stays_off", 32'(bus.alarm_req), 0);

    // Unstopped ring lasts exactly ALARM_HOLD_SEC pulses
    load(1'b0, 5'd7, 6'd29, 3'd1);
    cyc(241);
    check("hold_rise", 32'(bus.alarm_req), 1);
    hi_pulses = 0;
    for (int k = 2; k <= 260; k++) begin
      cyc(1);
      if (bus.sec_pulse && bus.alarm_req) hi_pulses++;
      if (k == 240) check("hold_last", 32'(bus.alarm_req), 1);
      if (k == 241) check("hold_drop", 32'(bus.alarm_req), 0);
    end
    check("hold_pulses", 32'(hi_pulses), 60);
    check("no_retrig", 32'(bus.alarm_req), 0);

    // Stop coinciding with trigger
    load(1'b0, 5'd7, 6'd29, 3'd1);
    cyc(240);
    pulse_stop();
    check("stop_vs_trig", 32'(bus.alarm_req), 0);
    cyc(8);
    check("stop_vs_trig_hold", 32'(bus.alarm_req), 0);

    // Enable falling mid-ring keeps ringing; time load cancels
    load(1'b0, 5'd7, 6'd29, 3'd1);
    cyc(241);
    check("en_ring", 32'(bus.alarm_req), 1);
    bus.alarm_enable = 1'b0;
    cyc(8);
    check("en_fall_keeps", 32'(bus.alarm_req), 1);
    load(1'b0, 5'd12, 6'd0, 3'd3);
    check("tload_cancels", 32'(bus.alarm_req), 0);
    load(1'b0, 5'd7, 6'd29, 3'd1);
    cyc(245);
    check("disabled_no_ring", 32'(bus.alarm_req), 0);
    bus.alarm_enable = 1'b1;

`ifdef ALARM_SNOOZE_EN
    load(1'b0, 5'd7, 6'd29, 3'd1);
    cyc(241);
    check("snz_ring", 32'(bus.alarm_req), 1);
    cyc(11);
    bus.snooze = 1'b1;
    cyc(1);
    bus.snooze = 1'b0;
    check("snz_drop", 32'(bus.alarm_req), 0);
    cyc(1187);
    check("snz_wait", 32'(bus.alarm_req), 0);
    check("snz_min", 32'(bus.min), 35);
    cyc(1);
    check("snz_rering", 32'(bus.alarm_req), 1);
    bus.stop   = 1'b1;
    bus.snooze = 1'b1;
    cyc(1);
    bus.stop   = 1'b0;
    bus.snooze = 1'b0;
    check("snz_stop_wins", 32'(bus.alarm_req), 0);
    cyc(1300);
    check("snz_stop_idle", 32'(bus.alarm_req), 0);
`endif

    // Reset in the middle of a ring
    load(1'b0, 5'd7, 6'd29, 3'd1);
    cyc(241);
    check("mid_ring", 32'(bus.alarm_req), 1);
    reset = 1'b1;
    cyc(1);
    check("rst_ring_req",  32'(bus.alarm_req), 0);
    check("rst_ring_hour", 32'(bus.hour), 0);
    check("rst_ring_wkd",  32'(bus.weekday), 1);
    reset = 1'b0;
    cyc(8);
    check("rst_ring_stay", 32'(bus.alarm_req), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
